// File: rtl/axi_rd_pkg.sv
// Shared constants for the AXI read-channel arbiter: default widths, queue depth
// and the arbiter FSM state encoding.
package axi_rd_pkg;

  localparam int DEF_NUM_DECOMPRESSOR = 2;
  localparam int DEF_ADDR_W           = 64;
  localparam int DEF_LEN_W            = 8;
  localparam int DEF_DATA_W           = 512;
  localparam int DEF_ORDER_DEPTH      = 8;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t IDLE  = 1'b0;
  localparam arb_state_t ISSUE = 1'b1;

  // Index width that stays at least one bit wide for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rd_order_q.sv
// In-order owner queue: one one-hot requester ID per outstanding AR burst.
// Occupancy is counter-based so every one of the DEPTH entries is usable.
module axi_rd_order_q
  import axi_rd_pkg::*;
#(
  parameter int W     = DEF_NUM_DECOMPRESSOR,
  parameter int DEPTH = DEF_ORDER_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = idx_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin AR arbiter with in-order R steering for the decompressor array.
// Optional AXI_RD_ARB_STALL_CNT_EN adds a saturating AR stall-cycle counter.
module axi_rd_arbiter
  import axi_rd_pkg::*;
#(
  parameter int NUM_DECOMPRESSOR = DEF_NUM_DECOMPRESSOR,
  parameter int ADDR_W           = DEF_ADDR_W,
  parameter int LEN_W            = DEF_LEN_W,
  parameter int DATA_W           = DEF_DATA_W,
  parameter int ORDER_DEPTH      = DEF_ORDER_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_DECOMPRESSOR-1:0]        s_arvalid,
  input  logic [NUM_DECOMPRESSOR*ADDR_W-1:0] s_araddr,
  input  logic [NUM_DECOMPRESSOR*LEN_W-1:0]  s_arlen,
  output logic [NUM_DECOMPRESSOR-1:0]        s_arready,
  output logic                               m_arvalid,
  output logic [ADDR_W-1:0]                  m_araddr,
  output logic [LEN_W-1:0]                   m_arlen,
  input  logic                               m_arready,
  input  logic                               m_rvalid,
  input  logic [DATA_W-1:0]                  m_rdata,
  input  logic                               m_rlast,
  output logic                               m_rready,
  output logic [NUM_DECOMPRESSOR-1:0]        s_rvalid,
  output logic [DATA_W-1:0]                  s_rdata,
  output logic                               s_rlast,
  input  logic [NUM_DECOMPRESSOR-1:0]        s_rready,
  output logic [$clog2(ORDER_DEPTH):0]       outstanding
`ifdef AXI_RD_ARB_STALL_CNT_EN
  ,
  output logic [31:0]                        ar_stall_cnt
`endif
);

  localparam int N     = NUM_DECOMPRESSOR;
  localparam int IDX_W = idx_w(N);
  localparam int CNT_W = $clog2(ORDER_DEPTH) + 1;
  localparam logic [IDX_W:0] N_C = (IDX_W + 1)'(N);

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [ADDR_W-1:0] ar_addr;
  logic [LEN_W-1:0]  ar_len;

  logic [2*N-1:0]    req2;
  logic [N-1:0]      rot;
  logic [IDX_W-1:0]  off;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  rr_next;
  logic [IDX_W:0]    sum;
  logic [IDX_W:0]    sum1;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              accept;

  logic [N-1:0]      q_head;
  logic [CNT_W-1:0]  q_count;
  logic              q_full;
  logic              q_empty;
  logic              pop;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req2 = {s_arvalid, s_arvalid};
    rot  = N'(req2 >> rr_ptr);
    off  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= N_C) sum = sum - N_C;
    winner = sum[IDX_W-1:0];
    sum1 = {1'b0, winner} + 1'b1;
    if (sum1 >= N_C) sum1 = sum1 - N_C;
    rr_next = sum1[IDX_W-1:0];
  end

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < N; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_addr = s_araddr[i*ADDR_W +: ADDR_W];
        sel_len  = s_arlen[i*LEN_W +: LEN_W];
      end
    end
  end

  assign accept = (state == IDLE) && (|s_arvalid) && !q_full;

  always_comb begin
    s_arready = '0;
    if (accept) s_arready[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      ar_addr <= '0;
      ar_len  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= ISSUE;
            rr_ptr  <= rr_next;
            ar_addr <= sel_addr;
            ar_len  <= sel_len;
          end
        end
        ISSUE: begin
          if (m_arready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_arvalid = (state == ISSUE);
  assign m_araddr  = ar_addr;
  assign m_arlen   = ar_len;

  axi_rd_order_q #(
    .W     (N),
    .DEPTH (ORDER_DEPTH),
    .CNT_W (CNT_W)
  ) u_order_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (s_arready),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // R beats are held off entirely while nothing is outstanding.
  assign s_rvalid    = q_empty ? '0 : (q_head & {N{m_rvalid}});
  assign m_rready    = !q_empty && (|(q_head & s_rready));
  assign s_rdata     = m_rdata;
  assign s_rlast     = m_rlast;
  assign pop         = m_rvalid && m_rready && m_rlast;
  assign outstanding = q_count;

`ifdef AXI_RD_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar_stall_cnt <= '0;
    end else if (m_arvalid && !m_arready && (ar_stall_cnt != 32'hFFFF_FFFF)) begin
      ar_stall_cnt <= ar_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with a queue-based reference model checked every cycle.
module tb_axi_rd_arbiter;

  localparam int N     = 2;
  localparam int AW    = 64;
  localparam int LW    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    s_arvalid = '0;
  logic [N*AW-1:0] s_araddr = '0;
  logic [N*LW-1:0] s_arlen = '0;
  logic [N-1:0]    s_arready;
  logic            m_arvalid;
  logic [AW-1:0]   m_araddr;
  logic [LW-1:0]   m_arlen;
  logic            m_arready = 1'b0;
  logic            m_rvalid = 1'b0;
  logic [DW-1:0]   m_rdata = '0;
  logic            m_rlast = 1'b0;
  logic            m_rready;
  logic [N-1:0]    s_rvalid;
  logic [DW-1:0]   s_rdata;
  logic            s_rlast;
  logic [N-1:0]    s_rready = '0;
  logic [3:0]      outstanding;
`ifdef AXI_RD_ARB_STALL_CNT_EN
  logic [31:0]     ar_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  axi_rd_arbiter #(
    .NUM_DECOMPRESSOR (N),
    .ADDR_W           (AW),
    .LEN_W            (LW),
    .DATA_W           (DW),
    .ORDER_DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_arvalid    (s_arvalid),
    .s_araddr     (s_araddr),
    .s_arlen      (s_arlen),
    .s_arready    (s_arready),
    .m_arvalid    (m_arvalid),
    .m_araddr     (m_araddr),
    .m_arlen      (m_arlen),
    .m_arready    (m_arready),
    .m_rvalid     (m_rvalid),
    .m_rdata      (m_rdata),
    .m_rlast      (m_rlast),
    .m_rready     (m_rready),
    .s_rvalid     (s_rvalid),
    .s_rdata      (s_rdata),
    .s_rlast      (s_rlast),
    .s_rready     (s_rready),
    .outstanding  (outstanding)
`ifdef AXI_RD_ARB_STALL_CNT_EN
    ,
    .ar_stall_cnt (ar_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending AR slot, a FIFO of owner indices, a round-robin start index.
  bit          md_busy;
  logic [63:0] md_addr;
  logic [7:0]  md_len;
  int          md_rr;
  int          md_q[$];
  longint      md_stall;

  always @(negedge clk) begin : model
    int          w;
    int          idx;
    int          head;
    logic [N-1:0] exp_ar;
    logic [N-1:0] exp_rv;
    logic         exp_mrr;
    logic         do_pop;
    if (!rst_n) begin
      md_busy  = 1'b0;
      md_addr  = '0;
      md_len   = '0;
      md_rr    = 0;
      md_stall = 0;
      md_q.delete();
    end else begin
      w = -1;
      if (!md_busy && md_q.size() < DEPTH) begin
        for (int k = 0; k < N; k++) begin
          idx = (md_rr + k) % N;
          if (w < 0 && ((s_arvalid >> idx) & 2'b01) != 0) w = idx;
        end
      end
      exp_ar = '0;
      if (w >= 0) exp_ar = 2'(1 << w);
      exp_rv  = '0;
      exp_mrr = 1'b0;
      head    = 0;
      if (md_q.size() > 0) begin
        head    = md_q[0];
        exp_rv  = m_rvalid ? 2'(1 << head) : 2'b00;
        exp_mrr = ((s_rready >> head) & 2'b01) != 0;
      end
      check("m.s_arready", s_arready, exp_ar);
      check("m.m_arvalid", m_arvalid, md_busy);
      check("m.m_araddr", m_araddr, md_addr);
      check("m.m_arlen", m_arlen, md_len);
      check("m.s_rvalid", s_rvalid, exp_rv);
      check("m.m_rready", m_rready, exp_mrr);
      check("m.s_rdata", s_rdata, m_rdata);
      check("m.s_rlast", s_rlast, m_rlast);
      check("m.outstanding", outstanding, md_q.size());
`ifdef AXI_RD_ARB_STALL_CNT_EN
      check("m.ar_stall_cnt", ar_stall_cnt, md_stall);
`endif
      do_pop = (md_q.size() > 0) && m_rvalid && exp_mrr && m_rlast;
      if (md_busy) begin
        if (m_arready) md_busy = 1'b0;
        else if (md_stall < 64'hFFFF_FFFF) md_stall++;
      end else if (w >= 0) begin
        md_busy = 1'b1;
        md_addr = s_araddr[w*AW +: AW];
        md_len  = s_arlen[w*LW +: LW];
        md_rr   = (w + 1) % N;
      end
      if (do_pop) void'(md_q.pop_front());
      if (w >= 0) md_q.push_back(w);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1);
  end

  initial begin
    int budget;
    repeat (3) tick();
    rst_n = 1'b1;
    #3;
    check("reset.outstanding", outstanding, 0);
    check("reset.m_arvalid", m_arvalid, 0);
    check("reset.s_arready", s_arready, 0);
    check("reset.m_rready", m_rready, 0);
    check("reset.s_rvalid", s_rvalid, 0);
    check("reset.m_araddr", m_araddr, 0);
    tick();

    // Simultaneous requests: requester 0 first, then 1.
    s_araddr  = {64'h2000, 64'h1000};
    s_arlen   = {8'd1, 8'd3};
    s_arvalid = 2'b11;
    m_arready = 1'b1;
    #3 check("rr.first_grant", s_arready, 2'b01);
    tick();
    s_arvalid = 2'b10;
    #3;
    check("rr.addr0", m_araddr, 64'h1000);
    check("rr.len0", m_arlen, 3);
    check("rr.no_accept_in_issue", s_arready, 0);
    tick();
    #3 check("rr.second_grant", s_arready, 2'b10);
    tick();
    s_arvalid = 2'b00;
    #3;
    check("rr.addr1", m_araddr, 64'h2000);
    check("rr.outstanding2", outstanding, 2);
    tick();

    // Steering: 4 beats to requester 0, then 2 to requester 1.
    s_rready = 2'b11;
    for (int b = 0; b < 6; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = 64'(100 + b);
      m_rlast  = (b == 3) || (b == 5);
      #3;
      check("steer.s_rvalid", s_rvalid, (b < 4) ? 2'b01 : 2'b10);
      check("steer.s_rlast", s_rlast, (b == 3) || (b == 5));
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #3 check("steer.drained", outstanding, 0);
    tick();

    // AR stall: m_arready low for five ISSUE cycles.
    s_arvalid = 2'b10;
    m_arready = 1'b0;
    #3 check("stall.grant1", s_arready, 2'b10);
    tick();
    s_arvalid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #3;
      check("stall.m_arvalid", m_arvalid, 1);
      check("stall.m_araddr", m_araddr, 64'h2000);
      check("stall.no_accept", s_arready, 0);
      tick();
    end
    m_arready = 1'b1;
    tick();
    #3;
    check("stall.grant0_after", s_arready, 2'b01);
`ifdef AXI_RD_ARB_STALL_CNT_EN
    check("stall.cnt5", ar_stall_cnt, 5);
`endif
    tick();
    s_arvalid = 2'b00;
    tick();

    // Head owner not ready: beat held, only head bit of s_rvalid set.
    s_rready = 2'b01;
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    m_rdata  = 64'hABCD;
    #3;
    check("hold.m_rready", m_rready, 0);
    check("hold.s_rvalid", s_rvalid, 2'b10);
    tick();
    s_rready = 2'b10;
    #3 check("hold.release", m_rready, 1);
    tick();
    s_rready = 2'b01;
    #3 check("hold.next_owner", s_rvalid, 2'b01);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = 2'b00;
    tick();

    // Fill the order queue to eight outstanding bursts.
    s_arvalid = 2'b11;
    m_arready = 1'b1;
    budget = 0;
    while (outstanding < 4'd8 && budget < 64) begin
      tick();
      budget++;
    end
    #3 check("full.outstanding8", outstanding, 8);
    tick();
    #3 check("full.blocked", s_arready, 0);
    tick();
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    s_rready = 2'b11;
    #3;
    check("full.pop_same_cycle_blocked", s_arready, 0);
    check("full.pop_ready", m_rready, 1);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #3;
    check("full.ninth_accept", |s_arready, 1);
    check("full.outstanding7", outstanding, 7);
    tick();
    s_arvalid = 2'b00;
    tick();

    // Reset in the middle of a burst.
    m_rvalid = 1'b1;
    m_rlast  = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n = 1'b1;
    #3;
    check("rst.outstanding", outstanding, 0);
    check("rst.m_arvalid", m_arvalid, 0);
    check("rst.m_rready", m_rready, 0);
    check("rst.s_rvalid", s_rvalid, 0);
    tick();
    m_rvalid = 1'b0;
    s_rready = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
